// File: rtl/vpu_lane_issue_ctrl_if.sv
// Request, FU-bank and result channels of the VPU lane issue controller.
// slave = controller side, master = decoder / FU bank / result consumer side.
interface vpu_lane_issue_ctrl_if #(
    parameter int NUM_FU          = 11,
    parameter int OPERAND_WIDTH   = 32,
    parameter int SRC_OPERAND_CNT = 3,
    parameter int DEPTH           = 8,
    parameter int TAG_W           = 4
);
    localparam int FU_SEL_W = $clog2(NUM_FU);
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic                                            req_valid_i;
    logic                                            req_ready_o;
    logic [FU_SEL_W-1:0]                             req_fu_i;
    logic [TAG_W-1:0]                                req_tag_i;
    logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0]   req_operand_i;
    logic [NUM_FU-1:0]                               fu_start_o;
    logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0]   fu_operand_o;
    logic [NUM_FU-1:0]                               fu_done_i;
    logic [NUM_FU-1:0][OPERAND_WIDTH-1:0]            fu_dout_i;
    logic                                            res_valid_o;
    logic                                            res_ready_i;
    logic [OPERAND_WIDTH-1:0]                        res_data_o;
    logic [TAG_W-1:0]                                res_tag_o;
    logic                                            res_err_o;
    logic [CNT_W-1:0]                                inflight_o;
    logic                                            spurious_o;
    logic                                            idle_o;

    modport slave (
        input  req_valid_i, req_fu_i, req_tag_i, req_operand_i,
        input  fu_done_i, fu_dout_i, res_ready_i,
        output req_ready_o, fu_start_o, fu_operand_o,
        output res_valid_o, res_data_o, res_tag_o, res_err_o,
        output inflight_o, spurious_o, idle_o
    );

    modport master (
        output req_valid_i, req_fu_i, req_tag_i, req_operand_i,
        output fu_done_i, fu_dout_i, res_ready_i,
        input  req_ready_o, fu_start_o, fu_operand_o,
        input  res_valid_o, res_data_o, res_tag_o, res_err_o,
        input  inflight_o, spurious_o, idle_o
    );
endinterface

// File: rtl/vpu_lane_issue_ctrl.sv
// Lane issue/retire controller: starts FUs, returns results in issue order; result at done+2 (illegal FU: accept+2).
// Stalls requests on full queue or busy target FU; result register holds while res_ready_i is low.
module vpu_lane_issue_ctrl #(
    parameter int NUM_FU          = 11,
    parameter int OPERAND_WIDTH   = 32,
    parameter int SRC_OPERAND_CNT = 3,
    parameter int DEPTH           = 8,
    parameter int TAG_W           = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vpu_lane_issue_ctrl_if.slave  io
);
    localparam int                FU_SEL_W = $clog2(NUM_FU);
    localparam int                PW       = $clog2(DEPTH);
    localparam logic [FU_SEL_W:0] NUM_FU_L = (FU_SEL_W + 1)'(NUM_FU);
    localparam logic [PW:0]       DEPTH_L  = (PW + 1)'(DEPTH);
    localparam logic [PW:0]       PTR_ONE  = (PW + 1)'(1);

    typedef struct packed {
        logic [FU_SEL_W-1:0] fu;
        logic [TAG_W-1:0]    tag;
        logic                ill;
    } q_ent_t;

    q_ent_t                   r_q [DEPTH];
    logic [PW:0]              r_wr_ptr;
    logic [PW:0]              r_rd_ptr;
    logic [NUM_FU-1:0]        r_busy;
    logic [NUM_FU-1:0]        r_hold_vld;
    logic [OPERAND_WIDTH-1:0] r_hold [NUM_FU];
    logic                     r_res_vld;
    logic [OPERAND_WIDTH-1:0] r_res_dat;
    logic [TAG_W-1:0]         r_res_tag;
    logic                     r_res_err;
    logic                     r_spurious;

    logic [PW:0]              w_count;
    logic                     w_req_ill;
    logic                     w_req_busy;
    logic                     w_req_rdy;
    logic                     w_accept;
    logic                     w_head_cmp;
    logic                     w_retire;
    logic [NUM_FU-1:0]        w_head_oh;
    logic [NUM_FU-1:0]        w_start;
    logic [OPERAND_WIDTH-1:0] w_head_dat;
    q_ent_t                   w_head;
    q_ent_t                   w_push;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_req_ill = ({1'b0, io.req_fu_i} >= NUM_FU_L);
    assign w_head    = r_q[r_rd_ptr[PW-1:0]];
    assign w_push    = '{fu: io.req_fu_i, tag: io.req_tag_i, ill: w_req_ill};

    // Out-of-range FU indices never match the loop, so they read as not busy.
    always_comb begin
        w_req_busy = 1'b0;
        w_head_cmp = w_head.ill;
        w_head_dat = '0;
        w_head_oh  = '0;
        w_start    = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (io.req_fu_i == FU_SEL_W'(f)) begin
                w_req_busy = r_busy[f];
            end
            if (!w_head.ill && (w_head.fu == FU_SEL_W'(f))) begin
                w_head_cmp   = r_hold_vld[f];
                w_head_dat   = r_hold[f];
                w_head_oh[f] = 1'b1;
            end
            w_start[f] = w_accept && !w_req_ill && (io.req_fu_i == FU_SEL_W'(f));
        end
        if (w_count == '0) begin
            w_head_cmp = 1'b0;
        end
    end

    assign w_req_rdy = (w_count < DEPTH_L) && (w_req_ill || !w_req_busy);
    assign w_accept  = io.req_valid_i && w_req_rdy;
    assign w_retire  = w_head_cmp && (!r_res_vld || io.res_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            for (int f = 0; f < NUM_FU; f++) begin
                r_hold[f] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_busy     <= '0;
            r_hold_vld <= '0;
            r_res_vld  <= 1'b0;
            r_res_dat  <= '0;
            r_res_tag  <= '0;
            r_res_err  <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            if (w_accept) begin
                r_q[r_wr_ptr[PW-1:0]] <= w_push;
                r_wr_ptr              <= r_wr_ptr + PTR_ONE;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // A retiring FU always has hold_vld set, so capture and clear never collide.
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_start[f]) begin
                    r_busy[f] <= 1'b1;
                end else if (w_retire && w_head_oh[f]) begin
                    r_busy[f] <= 1'b0;
                end
                if (io.fu_done_i[f] && r_busy[f] && !r_hold_vld[f]) begin
                    r_hold_vld[f] <= 1'b1;
                    r_hold[f]     <= io.fu_dout_i[f];
                end else if (w_retire && w_head_oh[f]) begin
                    r_hold_vld[f] <= 1'b0;
                end
                if (io.fu_done_i[f] && !(r_busy[f] && !r_hold_vld[f])) begin
                    r_spurious <= 1'b1;
                end
            end
            if (w_retire) begin
                r_res_vld <= 1'b1;
                r_res_dat <= w_head.ill ? '0 : w_head_dat;
                r_res_tag <= w_head.tag;
                r_res_err <= w_head.ill;
            end else if (r_res_vld && io.res_ready_i) begin
                r_res_vld <= 1'b0;
            end
        end
    end

    assign io.req_ready_o  = w_req_rdy;
    assign io.fu_start_o   = w_start;
    assign io.fu_operand_o = io.req_operand_i;
    assign io.res_valid_o  = r_res_vld;
    assign io.res_data_o   = r_res_dat;
    assign io.res_tag_o    = r_res_tag;
    assign io.res_err_o    = r_res_err;
    assign io.inflight_o   = w_count;
    assign io.spurious_o   = r_spurious;
    assign io.idle_o       = (w_count == '0) && !r_res_vld;
endmodule

// File: tb/tb_vpu_lane_issue_ctrl.sv
// Bench for vpu_lane_issue_ctrl: directed scenarios plus random traffic against an in-order queue model.
module tb_vpu_lane_issue_ctrl;
    localparam int NUM_FU = 11;
    localparam int OW     = 32;
    localparam int SRC    = 3;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 4;
    localparam int FSW    = $clog2(NUM_FU);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpu_lane_issue_ctrl_if #(.NUM_FU(NUM_FU), .OPERAND_WIDTH(OW), .SRC_OPERAND_CNT(SRC),
                             .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    vpu_lane_issue_ctrl #(.NUM_FU(NUM_FU), .OPERAND_WIDTH(OW), .SRC_OPERAND_CNT(SRC),
                          .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        int          fu;
        int          tag;
        bit          ill;
        bit          dn;
        logic [31:0] dat;
    } ent_t;

    // Reference model: ops in accept order, plus the result register.
    ent_t        q[$];
    bit          m_ov;
    logic [31:0] m_dat;
    int          m_tag;
    bit          m_err;
    bit          m_spur;

    // Behavioural FUs driven by the bench.
    int          fu_cnt [NUM_FU];
    logic [31:0] fu_res [NUM_FU];

    bit                d_vld;
    int                d_fu;
    int                d_tag;
    bit                d_rdy;
    int                d_lat;
    logic [NUM_FU-1:0] d_inj;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ov   = 1'b0;
        m_dat  = '0;
        m_tag  = 0;
        m_err  = 1'b0;
        m_spur = 1'b0;
    endtask

    task automatic check_outputs();
        chk("res_valid", bus.res_valid_o, m_ov);
        chk("res_data", bus.res_data_o, m_dat);
        chk("res_tag", bus.res_tag_o, m_tag);
        chk("res_err", bus.res_err_o, m_err);
        chk("inflight", bus.inflight_o, q.size());
        chk("idle", bus.idle_o, (q.size() == 0) && !m_ov);
        chk("spurious", bus.spurious_o, m_spur);
    endtask

    task automatic step();
        bit                  busy_hit, p_rdy, acc, ret, found;
        logic [NUM_FU-1:0]   done, p_start;
        logic [SRC*OW-1:0]   ops;
        ent_t                e;
        @(negedge clk);
        for (int k = 0; k < SRC; k++) ops[k*OW +: OW] = $urandom;
        bus.req_valid_i   = d_vld;
        bus.req_fu_i      = FSW'(d_fu);
        bus.req_tag_i     = TAG_W'(d_tag);
        bus.req_operand_i = ops;
        bus.res_ready_i   = d_rdy;
        done = d_inj;
        for (int f = 0; f < NUM_FU; f++) begin
            if (fu_cnt[f] == 1) done[f] = 1'b1;
            bus.fu_dout_i[f] = fu_res[f];
        end
        bus.fu_done_i = done;
        #1;
        busy_hit = 1'b0;
        foreach (q[i]) if (!q[i].ill && q[i].fu == d_fu) busy_hit = 1'b1;
        p_rdy   = (q.size() < DEPTH) && !busy_hit;
        acc     = d_vld && p_rdy;
        p_start = '0;
        if (acc && d_fu < NUM_FU) p_start[d_fu] = 1'b1;
        chk("req_ready", bus.req_ready_o, p_rdy);
        chk("fu_start", bus.fu_start_o, p_start);
        chk("fu_operand", bus.fu_operand_o, ops);
        check_outputs();
        // Next state: retire decision uses pre-edge completion status.
        ret = (q.size() > 0) && (q[0].ill || q[0].dn) && (!m_ov || d_rdy);
        for (int f = 0; f < NUM_FU; f++) begin
            if (done[f]) begin
                found = 1'b0;
                foreach (q[i]) begin
                    if (!q[i].ill && q[i].fu == f) begin
                        found = 1'b1;
                        if (!q[i].dn) begin
                            q[i].dn  = 1'b1;
                            q[i].dat = fu_res[f];
                        end else begin
                            m_spur = 1'b1;
                        end
                    end
                end
                if (!found) m_spur = 1'b1;
            end
        end
        if (ret) begin
            m_ov  = 1'b1;
            m_dat = q[0].ill ? 32'h0 : q[0].dat;
            m_tag = q[0].tag;
            m_err = q[0].ill;
            void'(q.pop_front());
        end else if (m_ov && d_rdy) begin
            m_ov = 1'b0;
        end
        if (acc) begin
            e.fu  = d_fu;
            e.tag = d_tag;
            e.ill = (d_fu >= NUM_FU);
            e.dn  = 1'b0;
            e.dat = '0;
            q.push_back(e);
        end
        for (int f = 0; f < NUM_FU; f++) if (fu_cnt[f] > 0) fu_cnt[f]--;
        if (acc && d_fu < NUM_FU) begin
            fu_cnt[d_fu] = d_lat;
            fu_res[d_fu] = $urandom;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.fu_done_i   = '0;
        #1;
        model_clear();
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_steps(input int n);
        d_vld = 1'b0;
        d_rdy = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        d_vld = 0; d_fu = 0; d_tag = 0; d_rdy = 1; d_lat = 1; d_inj = '0;
        bus.req_valid_i = 1'b0; bus.req_fu_i = '0; bus.req_tag_i = '0;
        bus.req_operand_i = '0; bus.fu_done_i = '0; bus.fu_dout_i = '0;
        bus.res_ready_i = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_cnt[f] = 0;
            fu_res[f] = '0;
        end
        model_clear();
        do_reset();

        // Single op on FU2, done 3 cycles after start.
        d_vld = 1; d_fu = 2; d_tag = 5; d_lat = 3; d_rdy = 1;
        step();
        fu_res[2] = 32'h3F800000;
        d_vld = 0;
        repeat (4) step();
        chk("t1_not_yet", bus.res_valid_o, 1'b0);
        step();
        chk("t1_valid", bus.res_valid_o, 1'b1);
        chk("t1_data", bus.res_data_o, 32'h3F800000);
        chk("t1_tag", bus.res_tag_o, 5);
        chk("t1_err", bus.res_err_o, 1'b0);
        idle_steps(4);

        // Out-of-order completion, in-order results.
        d_vld = 1; d_fu = 3; d_tag = 1; d_lat = 10; step();
        d_fu = 0; d_tag = 2; d_lat = 1; step();
        idle_steps(16);

        // Fill to DEPTH with the consumer stalled, then drain.
        d_rdy = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            d_vld = 1; d_fu = i % NUM_FU; d_tag = i; d_lat = 1 + (i % 4);
            step();
        end
        chk("t3_full_ready", bus.req_ready_o, 1'b0);
        chk("t3_full_cnt", bus.inflight_o, DEPTH);
        idle_steps(14);

        // Same FU requested back to back.
        d_vld = 1; d_fu = 5; d_lat = 4; d_rdy = 1;
        for (int i = 0; i < 14; i++) begin
            d_tag = i;
            step();
        end
        idle_steps(10);

        // Illegal FU index, then a spurious done on an idle FU.
        chk("t5_spur_clear", bus.spurious_o, 1'b0);
        d_vld = 1; d_fu = 13; d_tag = 7; step();
        d_vld = 0; step();
        chk("t5_not_yet", bus.res_valid_o, 1'b0);
        step();
        chk("t5_valid", bus.res_valid_o, 1'b1);
        chk("t5_err", bus.res_err_o, 1'b1);
        chk("t5_tag", bus.res_tag_o, 7);
        chk("t5_data", bus.res_data_o, 32'h0);
        d_inj = 11'b000_0001_0000; step();
        d_inj = '0; step();
        chk("t5_spur_set", bus.spurious_o, 1'b1);
        idle_steps(5);
        chk("t5_spur_sticky", bus.spurious_o, 1'b1);

        // Reset with ops in flight and a result pending.
        d_rdy = 0; d_vld = 1; d_fu = 14; d_tag = 9; step();
        for (int i = 0; i < 3; i++) begin
            d_fu = 6 + i; d_tag = i; d_lat = 6; step();
        end
        chk("t6_pre_valid", bus.res_valid_o, 1'b1);
        do_reset();
        idle_steps(10);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            d_vld = ($urandom_range(0, 9) < 6);
            d_fu  = ($urandom_range(0, 19) < 18) ? $urandom_range(0, NUM_FU - 1)
                                                 : $urandom_range(NUM_FU, 15);
            d_tag = $urandom_range(0, 15);
            d_rdy = ($urandom_range(0, 9) < 7);
            d_lat = $urandom_range(1, 8);
            step();
            if (c == 1500) do_reset();
        end
        idle_steps(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
